// File: rtl/dmi_pkg.sv
// Shared definitions for the DMI request path: dmistat encodings, FSM state type
// and default bus widths.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  localparam logic [1:0] DMISTAT_OK   = 2'd0;
  localparam logic [1:0] DMISTAT_FAIL = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } dmi_state_e;

endpackage

// File: rtl/dmi_core_req_ctrl.sv
// Core-clock DMI request controller: turns synchronized JTAG access pulses into a
// single valid/ready request, waits for the response and reports dmistat.
module dmi_core_req_ctrl
  import dmi_pkg::*;
#(
  parameter int ADDR_W  = DMI_ADDR_W,
  parameter int DATA_W  = DMI_DATA_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_en,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              dmi_reset,
  input  logic              dmi_hard_reset,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_err,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dmistat
);

  // Timeout fires on the edge where the counter would step onto TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  dmi_state_e        state_q, state_d;
  logic              req_write_q, req_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [1:0]        dmistat_q, dmistat_d;
  logic              complete, fail, overrun;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    complete    = 1'b0;
    fail        = 1'b0;
    overrun     = reg_en && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (reg_en && (dmistat_q == DMISTAT_OK)) begin
          state_d     = ST_REQ;
          req_write_d = reg_wr_en;
          req_addr_d  = reg_addr;
          req_wdata_d = reg_wdata;
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          if (rsp_valid) begin
            complete = 1'b1;
          end else begin
            state_d = ST_RSP;
            cnt_d   = '0;
          end
        end
      end
      ST_RSP: begin
        if (rsp_valid) begin
          complete = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          fail    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      if (rsp_err) begin
        fail = 1'b1;
      end else if (!req_write_q) begin
        rdata_d = rsp_rdata;
      end
    end

    // Sticky status: clear first so a same-cycle set wins; failure never
    // downgrades a pending busy-overrun.
    dmistat_d = dmi_reset ? DMISTAT_OK : dmistat_q;
    if (fail && (dmistat_d != DMISTAT_BUSY)) dmistat_d = DMISTAT_FAIL;
    if (overrun) dmistat_d = DMISTAT_BUSY;

    if (dmi_hard_reset) begin
      state_d     = ST_IDLE;
      req_write_d = 1'b0;
      req_addr_d  = '0;
      req_wdata_d = '0;
      rdata_d     = rdata_q;
      cnt_d       = '0;
      done_d      = 1'b0;
      dmistat_d   = DMISTAT_OK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      dmistat_q   <= DMISTAT_OK;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      dmistat_q   <= dmistat_d;
    end
  end

  assign req_valid = (state_q == ST_REQ);
  assign busy      = (state_q != ST_IDLE);
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign dmistat   = dmistat_q;

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// Self-checking bench for dmi_core_req_ctrl: directed scenarios plus randomized
// accesses checked against a transaction-level outcome model.
module tb_dmi_core_req_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_en, reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          dmi_reset, dmi_hard_reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] rdata;
  logic          busy, done;
  logic [1:0]    dmistat;

  int checks = 0;
  int errors = 0;

  // Reference model state: last good read data and sticky status.
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_stat;

  dmi_core_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .rdata(rdata), .busy(busy), .done(done), .dmistat(dmistat)
  );

  always #5 clk = ~clk;

  // Advance n edges; outputs are observed 1 time unit after each edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_pulses();
    reg_en = 0; reg_wr_en = 0; dmi_reset = 0; dmi_hard_reset = 0;
    req_ready = 0; rsp_valid = 0; rsp_err = 0;
  endtask

  task automatic start_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_en = 1; reg_wr_en = wr; reg_addr = a; reg_wdata = d;
    step();
    reg_en = 0; reg_wr_en = 0;
  endtask

  task automatic test_reset();
    clear_pulses();
    reg_addr = '0; reg_wdata = '0; rsp_rdata = '0;
    rst = 1;
    step(2);
    rst = 0;
    m_rdata = '0; m_stat = 2'd0;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL reset_dmistat got=%0d exp=0", dmistat); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if ({req_write, req_addr, req_wdata} !== '0) begin errors++; $display("FAIL reset_req_fields got=%0b/%h/%h exp=0", req_write, req_addr, req_wdata); end
  endtask

  task automatic test_read();
    start_access(1'b0, 7'h11, $urandom());
    checks++; if (req_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rd_valid_latency got=%0b/%0b exp=1/1", req_valid, busy); end
    checks++; if (req_addr !== 7'h11 || req_write !== 1'b0) begin errors++; $display("FAIL rd_req_addr got=%h/%0b exp=11/0", req_addr, req_write); end
    step();
    req_ready = 1;
    step();
    req_ready = 0;
    checks++; if (req_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_after_hs got=%0b/%0b exp=0/1", req_valid, busy); end
    step(2);
    rsp_valid = 1; rsp_rdata = 32'hDEADBEEF;
    step();
    rsp_valid = 0;
    m_rdata = 32'hDEADBEEF;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rd_done got=%0b/%0b exp=1/0", done, busy); end
    checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rd_rdata got=%h exp=%h", rdata, m_rdata); end
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL rd_dmistat got=%0d exp=0", dmistat); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_done_single got=%0b exp=0", done); end
  endtask

  task automatic test_write_same_cycle();
    start_access(1'b1, 7'h2A, 32'h12345678);
    checks++; if (req_write !== 1'b1 || req_wdata !== 32'h12345678 || req_valid !== 1'b1) begin
      errors++; $display("FAIL wr_req got=%0b/%h/%0b exp=1/12345678/1", req_write, req_wdata, req_valid); end
    req_ready = 1; rsp_valid = 1; rsp_rdata = $urandom();
    step();
    req_ready = 0; rsp_valid = 0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wr_done got=%0b/%0b exp=1/0", done, busy); end
    checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL wr_rdata got=%h exp=%h", rdata, m_rdata); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wr_after got=%0b/%0b exp=0/0", busy, done); end
  endtask

  task automatic test_backpressure_error();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom()); d = $urandom();
    start_access(1'b0, a, d);
    for (int i = 0; i < 10; i++) begin
      reg_addr = AW'($urandom()); reg_wdata = $urandom();
      rsp_valid = 1'($urandom()); rsp_rdata = $urandom();
      step();
      checks++; if (req_valid !== 1'b1 || req_addr !== a || req_wdata !== d || req_write !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL bp_stable_%0d got=%0b/%h/%h exp=1/%h/%h", i, req_valid, req_addr, req_wdata, a, d); end
    end
    rsp_valid = 0;
    req_ready = 1;
    step();
    req_ready = 0;
    rsp_valid = 1; rsp_err = 1; rsp_rdata = $urandom();
    step();
    rsp_valid = 0; rsp_err = 0;
    m_stat = 2'd2;
    checks++; if (dmistat !== 2'd2 || done !== 1'b1 || rdata !== m_rdata) begin
      errors++; $display("FAIL err_status got=%0d/%0b/%h exp=2/1/%h", dmistat, done, rdata, m_rdata); end
    start_access(1'b0, 7'h05, '0);
    checks++; if (req_valid !== 1'b0 || busy !== 1'b0 || dmistat !== 2'd2) begin
      errors++; $display("FAIL err_drop got=%0b/%0b/%0d exp=0/0/2", req_valid, busy, dmistat); end
    dmi_reset = 1;
    step();
    dmi_reset = 0;
    m_stat = 2'd0;
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL dmireset got=%0d exp=0", dmistat); end
    start_access(1'b1, 7'h06, 32'hA5A5A5A5);
    checks++; if (req_valid !== 1'b1 || req_addr !== 7'h06) begin errors++; $display("FAIL accept_after_reset got=%0b/%h exp=1/06", req_valid, req_addr); end
    req_ready = 1; rsp_valid = 1;
    step();
    req_ready = 0; rsp_valid = 0;
    step();
  endtask

  task automatic test_timeout();
    start_access(1'b0, 7'h33, '0);
    req_ready = 1;
    step();
    req_ready = 0;
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k < TO) begin
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_wait_%0d got=%0b/%0b exp=0/1", k, done, busy); end
      end
    end
    m_stat = 2'd2;
    checks++; if (done !== 1'b1 || dmistat !== 2'd2 || busy !== 1'b0 || rdata !== m_rdata) begin
      errors++; $display("FAIL to_fire got=%0b/%0d/%0b/%h exp=1/2/0/%h", done, dmistat, busy, rdata, m_rdata); end
    rsp_valid = 1; rsp_rdata = $urandom();
    step();
    rsp_valid = 0;
    checks++; if (done !== 1'b0 || rdata !== m_rdata) begin errors++; $display("FAIL to_late_rsp got=%0b/%h exp=0/%h", done, rdata, m_rdata); end
    dmi_reset = 1;
    step();
    dmi_reset = 0;
    m_stat = 2'd0;
  endtask

  task automatic test_overrun();
    logic [DW-1:0] d;
    start_access(1'b0, 7'h44, '0);
    req_ready = 1;
    step();
    req_ready = 0;
    start_access(1'b1, 7'h55, $urandom());
    m_stat = 2'd3;
    checks++; if (dmistat !== 2'd3 || busy !== 1'b1 || req_addr !== 7'h44) begin
      errors++; $display("FAIL ovr_set got=%0d/%0b/%h exp=3/1/44", dmistat, busy, req_addr); end
    d = $urandom();
    rsp_valid = 1; rsp_rdata = d;
    step();
    rsp_valid = 0;
    m_rdata = d;
    checks++; if (done !== 1'b1 || rdata !== m_rdata || dmistat !== 2'd3) begin
      errors++; $display("FAIL ovr_complete got=%0b/%h/%0d exp=1/%h/3", done, rdata, dmistat, m_rdata); end
    dmi_reset = 1;
    step();
    dmi_reset = 0;
    start_access(1'b0, 7'h46, '0);
    start_access(1'b0, 7'h47, '0);
    req_ready = 1; rsp_valid = 1; rsp_err = 1; rsp_rdata = $urandom();
    step();
    req_ready = 0; rsp_valid = 0; rsp_err = 0;
    checks++; if (done !== 1'b1 || dmistat !== 2'd3 || rdata !== m_rdata) begin
      errors++; $display("FAIL ovr_err_keeps3 got=%0b/%0d/%h exp=1/3/%h", done, dmistat, rdata, m_rdata); end
    dmi_reset = 1;
    step();
    dmi_reset = 0;
    m_stat = 2'd0;
  endtask

  task automatic test_hard_reset();
    start_access(1'b0, 7'h60, '0);
    req_ready = 1;
    step();
    req_ready = 0;
    start_access(1'b0, 7'h61, '0);
    dmi_hard_reset = 1;
    step();
    dmi_hard_reset = 0;
    checks++; if (busy !== 1'b0 || dmistat !== 2'd0 || done !== 1'b0 || req_valid !== 1'b0) begin
      errors++; $display("FAIL hrst_state got=%0b/%0d/%0b/%0b exp=0/0/0/0", busy, dmistat, done, req_valid); end
    checks++; if (rdata !== m_rdata || req_addr !== '0) begin errors++; $display("FAIL hrst_regs got=%h/%h exp=%h/0", rdata, req_addr, m_rdata); end
    rsp_valid = 1; rsp_rdata = ~m_rdata;
    step();
    rsp_valid = 0;
    checks++; if (done !== 1'b0 || rdata !== m_rdata) begin errors++; $display("FAIL hrst_stray got=%0b/%h exp=0/%h", done, rdata, m_rdata); end
    reg_en = 1; dmi_hard_reset = 1; reg_addr = 7'h62;
    step();
    reg_en = 0; dmi_hard_reset = 0;
    checks++; if (req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hrst_vs_regen got=%0b/%0b exp=0/0", req_valid, busy); end
  endtask

  // Outcome of each access is decided from its response delay vs TIMEOUT.
  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic wr, err;
      logic [AW-1:0] a;
      logic [DW-1:0] d, rd;
      int dr, ds, last;
      if (m_stat != 2'd0) begin
        dmi_reset = 1;
        step();
        dmi_reset = 0;
        m_stat = 2'd0;
        checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL rnd_clear_%0d got=%0d exp=0", t, dmistat); end
      end
      wr = 1'($urandom()); err = ($urandom_range(3) == 0);
      a = AW'($urandom()); d = $urandom(); rd = $urandom();
      dr = $urandom_range(3); ds = $urandom_range(TO + 2);
      start_access(wr, a, d);
      checks++; if (req_valid !== 1'b1 || req_addr !== a || req_write !== wr || req_wdata !== d) begin
        errors++; $display("FAIL rnd_req_%0d got=%0b/%h/%0b/%h exp=1/%h/%0b/%h", t, req_valid, req_addr, req_write, req_wdata, a, wr, d); end
      step(dr);
      req_ready = 1;
      if (ds == 0) begin rsp_valid = 1; rsp_err = err; rsp_rdata = rd; end
      step();
      req_ready = 0; rsp_valid = 0; rsp_err = 0;
      last = (ds <= TO) ? ds : TO;
      for (int k = 1; k <= last; k++) begin
        if (k == ds) begin rsp_valid = 1; rsp_err = err; rsp_rdata = rd; end
        step();
        rsp_valid = 0; rsp_err = 0;
      end
      if (ds > TO) m_stat = 2'd2;
      else if (err) m_stat = 2'd2;
      else if (!wr) m_rdata = rd;
      checks++; if (done !== 1'b1 || busy !== 1'b0 || rdata !== m_rdata || dmistat !== m_stat) begin
        errors++; $display("FAIL rnd_end_%0d got=%0b/%0b/%h/%0d exp=1/0/%h/%0d", t, done, busy, rdata, dmistat, m_rdata, m_stat); end
      rsp_valid = 1; rsp_rdata = $urandom(); reg_wr_en = 1;
      step();
      rsp_valid = 0; reg_wr_en = 0;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== m_rdata) begin
        errors++; $display("FAIL rnd_idle_%0d got=%0b/%0b/%h exp=0/0/%h", t, done, busy, rdata, m_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_same_cycle();
    test_backpressure_error();
    test_timeout();
    test_overrun();
    test_hard_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
